// File: rtl/fp16_norm_round_pkg.sv
// Shared types and constants for the fp16 post-add normalize/round/pack stage.
package fp16_pkg;

  typedef enum logic [1:0] {
    FP_FINITE = 2'b00,
    FP_INF    = 2'b01,
    FP_NAN    = 2'b10,
    FP_RSVD   = 2'b11
  } fp_kind_e;

  localparam int unsigned FP16_BIAS    = 15;
  localparam int unsigned FP16_EXP_MAX = 31;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  // One bit wider than the incoming exponent so normalization never wraps.
  localparam int unsigned FP_EXP_W = 8;

  typedef struct packed {
    logic                       sign;
    logic signed [FP_EXP_W-1:0] exp;
    logic [12:0]                n;
    logic                       s;
    fp_kind_e                   kind;
    logic                       zero;
  } s1_t;

endpackage

// File: rtl/fp16_norm_round_if.sv
// Upstream sum / downstream result handshake bundle for fp16_norm_round.
interface fp16_norm_round_if #(
  parameter int unsigned EXP_IN_W = 7
);
  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic [EXP_IN_W-1:0] in_exp;
  logic [13:0]         in_mant;
  logic                in_sticky;
  logic [1:0]          in_kind;
  logic                out_valid;
  logic                out_ready;
  logic [15:0]         out_result;
  logic                out_ovf;
  logic                out_unf;
  logic                out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, in_kind, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky, in_kind, out_ready,
    output in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
  );
endinterface

// File: rtl/fp16_norm_round_lzc.sv
// 13-bit leading-zero counter; reports 13 when the input is all zero.
module fp16_lzc13 (
  input  logic [12:0] mant_i,
  output logic [3:0]  lzc_o
);

  always_comb begin
    lzc_o = 4'd13;
    // Ascending scan: the highest set bit is the last to win.
    for (int i = 0; i < 13; i++) begin
      if (mant_i[i]) lzc_o = 4'(12 - i);
    end
  end

endmodule

// File: rtl/fp16_norm_round.sv
// Two-stage normalize then round-to-nearest-even/pack of an unnormalized fp16 sum,
// with valid/ready backpressure at both stages.
module fp16_norm_round
  import fp16_pkg::*;
#(
  parameter int unsigned EXP_IN_W = 7,
  parameter int unsigned BIAS     = FP16_BIAS,
  parameter logic [15:0] QNAN     = FP16_QNAN
) (
  input logic             clk,
  input logic             rst,
  fp16_norm_round_if.slave bus
);

  localparam int ExpMax = 2 * BIAS + 1;

  logic adv1, adv2;

  logic s1_valid_q, s1_valid_d;
  s1_t  s1_q, s1_d, s1_new;

  logic        out_valid_q, out_valid_d;
  logic [15:0] out_result_q, out_result_d;
  logic        out_ovf_q, out_ovf_d;
  logic        out_unf_q, out_unf_d;
  logic        out_inexact_q, out_inexact_d;

  assign adv2         = !out_valid_q || bus.out_ready;
  assign adv1         = !s1_valid_q || adv2;
  assign bus.in_ready = adv1 && !rst;

  // ---------------------------------------------------------------- stage 1: normalize
  logic [3:0]                 lzc;
  logic signed [EXP_IN_W-1:0] in_exp_s;
  logic signed [FP_EXP_W-1:0] exp_ext;

  assign in_exp_s = bus.in_exp;
  assign exp_ext  = FP_EXP_W'(in_exp_s);

  fp16_lzc13 u_lzc (
    .mant_i (bus.in_mant[12:0]),
    .lzc_o  (lzc)
  );

  always_comb begin
    s1_new      = '0;
    s1_new.sign = bus.in_sign;
    s1_new.kind = fp_kind_e'(bus.in_kind);
    s1_new.zero = (bus.in_mant == 14'h0) && !bus.in_sticky;
    if (bus.in_mant[13]) begin
      s1_new.n   = bus.in_mant[13:1];
      s1_new.s   = bus.in_mant[1] | bus.in_mant[0] | bus.in_sticky;
      s1_new.exp = exp_ext + FP_EXP_W'(1);
    end else begin
      s1_new.n   = bus.in_mant[12:0] << lzc;
      s1_new.s   = s1_new.n[0] | bus.in_sticky;
      s1_new.exp = exp_ext - FP_EXP_W'(lzc);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (adv1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) s1_d = s1_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  // ---------------------------------------------------------------- stage 2: round/pack
  logic [15:0]                res;
  logic                       res_ovf, res_unf, res_inexact;
  logic signed [FP_EXP_W-1:0] e1, e2;
  logic [10:0]                frac_sum;
  logic                       g, up;

  always_comb begin
    res         = 16'h0000;
    res_ovf     = 1'b0;
    res_unf     = 1'b0;
    res_inexact = 1'b0;
    e1          = s1_q.exp;
    g           = s1_q.n[1];
    up          = g && (s1_q.s || s1_q.n[2]);
    frac_sum    = {1'b0, s1_q.n[11:2]} + {10'b0, up};
    e2          = e1 + FP_EXP_W'(frac_sum[10]);
    unique case (s1_q.kind)
      FP_INF:         res = {s1_q.sign, 5'h1F, 10'h000};
      FP_NAN, FP_RSVD: res = QNAN;
      FP_FINITE: begin
        if (s1_q.zero) begin
          res = {s1_q.sign, 15'h0000};
        end else if (s1_q.n == 13'h0 || int'(e1) <= 0) begin
          // Tiny results (including sticky-only residue) flush; no subnormals.
          res         = {s1_q.sign, 15'h0000};
          res_unf     = 1'b1;
          res_inexact = 1'b1;
        end else if (int'(e2) >= ExpMax) begin
          res         = {s1_q.sign, 5'h1F, 10'h000};
          res_ovf     = 1'b1;
          res_inexact = 1'b1;
        end else begin
          res         = {s1_q.sign, e2[4:0], frac_sum[9:0]};
          res_inexact = g | s1_q.s;
        end
      end
      default: res = QNAN;
    endcase
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_ovf_d     = out_ovf_q;
    out_unf_d     = out_unf_q;
    out_inexact_d = out_inexact_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d  = res;
        out_ovf_d     = res_ovf;
        out_unf_d     = res_unf;
        out_inexact_d = res_inexact;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= 16'h0000;
      out_ovf_q     <= 1'b0;
      out_unf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_ovf_q     <= out_ovf_d;
      out_unf_q     <= out_unf_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_ovf     = out_ovf_q;
  assign bus.out_unf     = out_unf_q;
  assign bus.out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp16_norm_round.sv
// Directed-vector bench for fp16_norm_round: rounding, exceptions, backpressure, reset.
module tb_fp16_norm_round;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fp16_norm_round_if #(.EXP_IN_W(7)) bus ();

  fp16_norm_round #(
    .EXP_IN_W (7),
    .BIAS     (15),
    .QNAN     (16'h7E00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic s, input logic [6:0] e, input logic [13:0] m,
                        input logic st, input logic [1:0] k);
    bus.in_sign   = s;
    bus.in_exp    = e;
    bus.in_mant   = m;
    bus.in_sticky = st;
    bus.in_kind   = k;
  endtask

  // Sends one vector with out_ready=1 and returns the first result plus its latency.
  task automatic run_one(input logic s, input logic [6:0] e, input logic [13:0] m,
                         input logic st, input logic [1:0] k,
                         output logic [15:0] r, output logic o, output logic u,
                         output logic x, output int lat);
    @(negedge clk);
    bus.out_ready = 1'b1;
    set_in(s, e, m, st, k);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    r = bus.out_result;
    o = bus.out_ovf;
    u = bus.out_unf;
    x = bus.out_inexact;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1'b0, 7'd0, 14'h0, 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_out: got valid=%b result=%h expected 0/0000",
               bus.out_valid, bus.out_result);
    end
    checks++;
    if ({bus.out_ovf, bus.out_unf, bus.out_inexact} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000",
               {bus.out_ovf, bus.out_unf, bus.out_inexact});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_carry();
    logic [15:0] r;
    logic        o, u, x;
    int          lat;
    run_one(1'b0, 7'd15, 14'h2000, 1'b0, 2'b00, r, o, u, x, lat);
    checks++;
    if (r !== 16'h4000 || {o, u, x} !== 3'b000) begin
      failures++;
      $display("FAIL carry: got %h flags=%b expected 4000 flags=000", r, {o, u, x});
    end
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL carry_latency: got %0d expected 2", lat);
    end
  endtask

  task automatic test_cancel();
    logic [15:0] r;
    logic        o, u, x;
    int          lat;
    run_one(1'b0, 7'd15, 14'h0004, 1'b0, 2'b00, r, o, u, x, lat);
    checks++;
    if (r !== 16'h1400 || {o, u, x} !== 3'b000 || lat !== 2) begin
      failures++;
      $display("FAIL cancel: got %h flags=%b lat=%0d expected 1400 flags=000 lat=2",
               r, {o, u, x}, lat);
    end
  endtask

  task automatic test_rne();
    logic [15:0] r;
    logic        o, u, x;
    int          lat;
    run_one(1'b0, 7'd15, {2'b01, 10'h001, 2'b10}, 1'b0, 2'b00, r, o, u, x, lat);
    checks++;
    if (r !== 16'h3C02 || {o, u, x} !== 3'b001) begin
      failures++;
      $display("FAIL rne_tie_odd: got %h flags=%b expected 3c02 flags=001", r, {o, u, x});
    end
    run_one(1'b0, 7'd15, {2'b01, 10'h000, 2'b10}, 1'b0, 2'b00, r, o, u, x, lat);
    checks++;
    if (r !== 16'h3C00 || {o, u, x} !== 3'b001) begin
      failures++;
      $display("FAIL rne_tie_even: got %h flags=%b expected 3c00 flags=001", r, {o, u, x});
    end
    run_one(1'b0, 7'd15, {2'b01, 10'h000, 2'b11}, 1'b0, 2'b00, r, o, u, x, lat);
    checks++;
    if (r !== 16'h3C01 || {o, u, x} !== 3'b001) begin
      failures++;
      $display("FAIL rne_above_half: got %h flags=%b expected 3c01 flags=001", r, {o, u, x});
    end
  endtask

  task automatic test_exceptions();
    logic [15:0] r;
    logic        o, u, x;
    int          lat;
    run_one(1'b0, 7'd30, {2'b01, 10'h3FF, 2'b10}, 1'b0, 2'b00, r, o, u, x, lat);
    checks++;
    if (r !== 16'h7C00 || {o, u, x} !== 3'b101) begin
      failures++;
      $display("FAIL overflow: got %h flags=%b expected 7c00 flags=101", r, {o, u, x});
    end
    run_one(1'b1, 7'd1, 14'h0800, 1'b0, 2'b00, r, o, u, x, lat);
    checks++;
    if (r !== 16'h8000 || {o, u, x} !== 3'b011) begin
      failures++;
      $display("FAIL underflow: got %h flags=%b expected 8000 flags=011", r, {o, u, x});
    end
    run_one(1'b0, 7'd15, 14'h1000, 1'b0, 2'b10, r, o, u, x, lat);
    checks++;
    if (r !== 16'h7E00 || {o, u, x} !== 3'b000 || lat !== 2) begin
      failures++;
      $display("FAIL nan: got %h flags=%b lat=%0d expected 7e00 flags=000 lat=2",
               r, {o, u, x}, lat);
    end
    run_one(1'b1, 7'd3, 14'h0000, 1'b0, 2'b01, r, o, u, x, lat);
    checks++;
    if (r !== 16'hFC00 || {o, u, x} !== 3'b000) begin
      failures++;
      $display("FAIL inf: got %h flags=%b expected fc00 flags=000", r, {o, u, x});
    end
    run_one(1'b0, 7'd0, 14'h1000, 1'b0, 2'b11, r, o, u, x, lat);
    checks++;
    if (r !== 16'h7E00 || {o, u, x} !== 3'b000) begin
      failures++;
      $display("FAIL reserved_kind: got %h flags=%b expected 7e00 flags=000", r, {o, u, x});
    end
    run_one(1'b1, 7'd20, 14'h0000, 1'b0, 2'b00, r, o, u, x, lat);
    checks++;
    if (r !== 16'h8000 || {o, u, x} !== 3'b000) begin
      failures++;
      $display("FAIL exact_zero: got %h flags=%b expected 8000 flags=000", r, {o, u, x});
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] vm[4];
    logic [6:0]  ve[4];
    logic [15:0] vr[4];
    int          in_idx;
    int          out_idx;
    vm[0] = 14'h2000; ve[0] = 7'd15; vr[0] = 16'h4000;
    vm[1] = 14'h0004; ve[1] = 7'd15; vr[1] = 16'h1400;
    vm[2] = 14'h1000; ve[2] = 7'd15; vr[2] = 16'h3C00;
    vm[3] = 14'h1000; ve[3] = 7'd20; vr[3] = 16'h5000;
    in_idx  = 0;
    out_idx = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 30 && out_idx < 4; cyc++) begin
      bus.in_valid  = (in_idx < 4);
      if (in_idx < 4) set_in(1'b0, ve[in_idx], vm[in_idx], 1'b0, 2'b00);
      bus.out_ready = (cyc >= 4);
      #1;
      if (cyc < 2) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_accept_c%0d: got in_ready=%b expected 1", cyc, bus.in_ready);
        end
      end else if (cyc < 4) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_stall_c%0d: got in_ready=%b expected 0", cyc, bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== vr[0]) begin
          failures++;
          $display("FAIL bp_hold_c%0d: got valid=%b result=%h expected 1/%h",
                   cyc, bus.out_valid, bus.out_result, vr[0]);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_result !== vr[out_idx] || cyc !== 4 + out_idx) begin
          failures++;
          $display("FAIL bp_order_%0d: got %h at cycle %0d expected %h at cycle %0d",
                   out_idx, bus.out_result, cyc, vr[out_idx], 4 + out_idx);
        end
        out_idx++;
      end
      if (bus.in_valid && bus.in_ready) in_idx++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (out_idx !== 4) begin
      failures++;
      $display("FAIL bp_count: got %0d results expected 4", out_idx);
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] r;
    logic        o, u, x;
    int          lat;
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_in(1'b0, 7'd15, 14'h2000, 1'b0, 2'b00);
    bus.in_valid = 1'b1;
    @(negedge clk);
    set_in(1'b0, 7'd15, 14'h0004, 1'b0, 2'b00);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h4000) begin
      failures++;
      $display("FAIL mid_prefill: got valid=%b result=%h expected 1/4000",
               bus.out_valid, bus.out_result);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 16'h0000 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got valid=%b result=%h in_ready=%b expected 0/0000/0",
               bus.out_valid, bus.out_result, bus.in_ready);
    end
    rst = 1'b0;
    run_one(1'b0, 7'd15, 14'h1000, 1'b0, 2'b00, r, o, u, x, lat);
    checks++;
    if (r !== 16'h3C00 || lat !== 2) begin
      failures++;
      $display("FAIL mid_post_reset: got %h lat=%0d expected 3c00 lat=2", r, lat);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_stale: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_carry();
    test_cancel();
    test_rne();
    test_exceptions();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
